// File: rtl/sm_to_2comp_rr_sched.sv
// Round-robin shared sign-magnitude to two's-complement converter.
// One requester is granted per word; the result is held on a valid/ready port.
module sm_to_2comp_rr_sched #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      out_data,
   output logic [IDW-1:0]    out_id,
   output logic              neg_zero,
   output logic              busy
);

   typedef enum logic [0:0] {StIdle, StHold} state_e;

   state_e         state_q, state_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic           out_valid_q, out_valid_d;
   logic [W-1:0]   out_data_q, out_data_d;
   logic [IDW-1:0] out_id_q, out_id_d;
   logic           neg_zero_q, neg_zero_d;

   logic           gnt_any;
   logic [IDW-1:0] gnt_idx;
   logic [IDW-1:0] scan_idx;
   logic [W-1:0]   sel_word;
   logic [W-1:0]   conv_word;
   logic           conv_nz;

   // First valid requester at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      scan_idx = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan_idx = IDW'((32'(rr_ptr_q) + k) % NREQ);
         if (!gnt_any && req_valid[scan_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = scan_idx;
         end
      end
   end

   assign sel_word = req_data[32'(gnt_idx)*W +: W];

   always_comb begin
      conv_nz = 1'b0;
      if (!sel_word[W-1]) begin
         conv_word = {1'b0, sel_word[W-2:0]};
      end else if (sel_word[W-2:0] == '0) begin
         conv_word = '0;
         conv_nz   = 1'b1;
      end else begin
         conv_word = (~{1'b0, sel_word[W-2:0]}) + W'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      neg_zero_d  = neg_zero_q;
      req_ready   = '0;
      unique case (state_q)
         StIdle: begin
            if (gnt_any) begin
               // Grant is suppressed while reset is held so no transfer can complete.
               req_ready   = rst ? '0 : (NREQ'(1) << gnt_idx);
               out_data_d  = conv_word;
               out_id_d    = gnt_idx;
               neg_zero_d  = conv_nz;
               out_valid_d = 1'b1;
               rr_ptr_d    = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
               state_d     = StHold;
            end
         end
         StHold: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         neg_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         neg_zero_q  <= neg_zero_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;
   assign neg_zero  = neg_zero_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_sm_to_2comp_rr_sched.sv
// Scoreboard bench for sm_to_2comp_rr_sched: directed vectors, expected results queued
// at issue and compared by a monitor on each output handshake.
module tb_sm_to_2comp_rr_sched;

   localparam int NREQ = 4;
   localparam int W    = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      out_data;
   logic [IDW-1:0]    out_id;
   logic              neg_zero;
   logic              busy;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [W-1:0]   data;
      logic           nz;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   // Hand-computed conversions for SM inputs 0..15.
   logic [W-1:0] conv_tab [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                   4'h0, 4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9};

   sm_to_2comp_rr_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id),
      .neg_zero  (neg_zero),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int id, input logic [W-1:0] d, input logic nz);
      exp_t e;
      e.id   = IDW'(id);
      e.data = d;
      e.nz   = nz;
      sb.push_back(e);
   endtask

   // Waits for req_ready[idx], checks the whole grant vector, returns just after the grant edge.
   task automatic wait_grant(input int idx, input string name);
      bit got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (req_ready[idx]) got = 1'b1;
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL %s: req_ready got %0h expected bit %0d within 20 cycles",
                  name, req_ready, idx);
      end else begin
         check(name, 32'(req_ready), 32'(1) << idx);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      bit done = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
         @(negedge clk);
         if (sb.size() == 0 && !out_valid) done = 1'b1;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL %s: pending got %0d expected 0", name, sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected output: got id=%0d data=%0h expected none", out_id, out_data);
         end else begin
            mon_e = sb.pop_front();
            check("out_id", 32'(out_id), 32'(mon_e.id));
            check("out_data", 32'(out_data), 32'(mon_e.data));
            check("neg_zero", 32'(neg_zero), 32'(mon_e.nz));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset out_data", 32'(out_data), 32'd0);
      check("reset out_id", 32'(out_id), 32'd0);
      check("reset neg_zero", 32'(neg_zero), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset req_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;

      // Every SM code through requester 0.
      for (int v = 0; v < 16; v++) begin
         push_exp(0, conv_tab[v], v == 8);
         req_data[3:0] = 4'(v);
         req_valid[0]  = 1'b1;
         wait_grant(0, "conv grant");
         req_valid[0]  = 1'b0;
      end
      drain("conv drain");

      // Reset in the middle of HOLD discards the pending word.
      out_ready       = 1'b0;
      req_data[11:8]  = 4'hF;
      req_valid[2]    = 1'b1;
      wait_grant(2, "hold grant");
      req_valid       = '0;
      @(negedge clk);
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      rst       = 1'b1;
      req_valid = 4'hF;
      #1;
      check("async rst out_valid", 32'(out_valid), 32'd0);
      check("async rst busy", 32'(busy), 32'd0);
      check("async rst req_ready", 32'(req_ready), 32'd0);
      check("async rst out_data", 32'(out_data), 32'd0);
      check("async rst out_id", 32'(out_id), 32'd0);
      for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = 4'(8 | i);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Round-robin with all requesters active; also the 2-cycle throughput pattern.
      push_exp(0, 4'b0000, 1'b1);
      push_exp(1, 4'b1111, 1'b0);
      push_exp(2, 4'b1110, 1'b0);
      push_exp(3, 4'b1101, 1'b0);
      push_exp(0, 4'b0000, 1'b1);
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         check("rr onehot", 32'($countones(req_ready) <= 1), 32'd1);
         check("rr out_valid phase", 32'(out_valid), 32'(cyc % 2));
         if (cyc % 2 == 0) check("rr grant", 32'(req_ready), 32'(1) << ((cyc / 2) % NREQ));
      end
      req_valid = '0;
      drain("rr drain");

      // Pointer moves past the last grant.
      req_data[11:8] = 4'b0011;
      req_valid[2]   = 1'b1;
      push_exp(2, 4'b0011, 1'b0);
      wait_grant(2, "ptr grant2");
      req_valid      = '0;
      drain("ptr drain1");
      push_exp(3, 4'b0101, 1'b0);
      push_exp(1, 4'b1111, 1'b0);
      req_data[7:4]   = 4'b1001;
      req_data[15:12] = 4'b0101;
      req_valid       = 4'b1010;
      wait_grant(3, "ptr grant3");
      req_valid[3]    = 1'b0;
      wait_grant(1, "ptr grant1");
      req_valid[1]    = 1'b0;
      drain("ptr drain2");

      // Backpressure keeps outputs frozen; next grant one cycle after the handshake.
      out_ready     = 1'b0;
      req_data[3:0] = 4'b1110;
      push_exp(0, 4'b1010, 1'b0);
      req_valid[0]  = 1'b1;
      wait_grant(0, "bp grant");
      req_valid[0]  = 1'b0;
      req_data[7:4] = 4'b0100;
      req_valid[1]  = 1'b1;
      push_exp(1, 4'b0100, 1'b0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp out_valid", 32'(out_valid), 32'd1);
         check("bp out_data", 32'(out_data), 32'hA);
         check("bp out_id", 32'(out_id), 32'd0);
         check("bp req_ready", 32'(req_ready), 32'd0);
         check("bp busy", 32'(busy), 32'd1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp handshake valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      check("bp after hs out_valid", 32'(out_valid), 32'd0);
      check("bp next grant", 32'(req_ready), 32'b0010);
      @(posedge clk);
      #1;
      req_valid = '0;
      drain("bp drain");

      check("scoreboard empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
